// File: rtl/rob_commit_if.sv
// Bundle of ROB head / flush / redirect / regfile-write signals seen by the
// in-order commit controller. The master side is the commit controller.
interface rob_commit_if;
   logic        rob_is_empty;
   logic        rob_head_ready;
   logic [31:0] rob_head_instr;
   logic [31:0] rob_head_val;
   logic        rob_pop;
   logic        rob_flushing_instr;
   logic [31:0] rob_instr_to_flush;
   logic        flush_req;
   logic [31:0] flush_tag;
   logic [31:0] flush_target;
   logic        flush_ack;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect;
   logic        dispatch_stall;
   logic        reg_wEn;
   logic [4:0]  reg_rd;
   logic [31:0] reg_data;
   logic        halted;
   logic [31:0] commit_count;

   modport master (
      input  rob_is_empty, rob_head_ready, rob_head_instr, rob_head_val,
      input  flush_req, flush_tag, flush_target,
      output rob_pop, rob_flushing_instr, rob_instr_to_flush,
      output flush_ack, pc_redirect_valid, pc_redirect, dispatch_stall,
      output reg_wEn, reg_rd, reg_data, halted, commit_count
   );

   modport slave (
      output rob_is_empty, rob_head_ready, rob_head_instr, rob_head_val,
      output flush_req, flush_tag, flush_target,
      input  rob_pop, rob_flushing_instr, rob_instr_to_flush,
      input  flush_ack, pc_redirect_valid, pc_redirect, dispatch_stall,
      input  reg_wEn, reg_rd, reg_data, halted, commit_count
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retire sequencer: pops a ready ROB head and writes the regfile on
// the same edge, sequences mispredict flush/recovery, and stops on halt.
module rob_commit_ctrl #(
   parameter int unsigned RECOVER_CYCLES = 2,
   parameter logic [4:0]  HALT_OPCODE    = 5'b11111
) (
   input  logic          i_clock,
   input  logic          i_reset,
   rob_commit_if.master  bus
);
   localparam int CW = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_RECOVER = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [31:0]   r_tag;
   logic [31:0]   r_target;
   logic [31:0]   r_count;

   logic          w_can_commit;
   logic          w_flush_ack;
   logic          w_commit_ok;
   logic          w_halt_commit;
   logic [4:0]    w_opcode;
   logic [4:0]    w_rd;
   logic          w_writer;
   logic          w_wen;
   logic          w_unused;

   assign w_opcode = bus.rob_head_instr[31:27];
   assign w_unused = ^bus.rob_head_instr[21:0];

   // Commit/flush qualification: accepting a flush blocks the pop that cycle
   // so the mispredicted branch never retires ahead of its own flush.
   always_comb begin
      w_can_commit  = (r_state == ST_RUN) || (r_state == ST_RECOVER);
      w_flush_ack   = bus.flush_req & w_can_commit;
      w_commit_ok   = bus.rob_head_ready & ~bus.rob_is_empty & w_can_commit & ~w_flush_ack;
      w_halt_commit = w_commit_ok & (w_opcode == HALT_OPCODE);
   end

   // Head decode: which opcodes write the regfile and to which register.
   always_comb begin
      w_writer = 1'b1;
      w_rd     = bus.rob_head_instr[26:22];
      case (w_opcode)
         5'b00111, 5'b00010, 5'b00110,
         5'b00001, 5'b00100, 5'b10110: w_writer = 1'b0;
         5'b00011:                     w_rd     = 5'd31;
         5'b10101:                     w_rd     = 5'd30;
         default:                      w_writer = 1'b1;
      endcase
      if (w_opcode == HALT_OPCODE) begin
         w_writer = 1'b0;
      end else begin
         w_writer = w_writer;
      end
      w_wen = w_commit_ok & w_writer & (w_rd != 5'd0);
   end

   // Next-state and recovery-counter logic; halt outranks flush accept.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (w_halt_commit)    w_state_nxt = ST_HALTED;
            else if (w_flush_ack) w_state_nxt = ST_FLUSH;
            else                  w_state_nxt = ST_RUN;
         end
         ST_FLUSH: begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = CW'(RECOVER_CYCLES);
         end
         ST_RECOVER: begin
            w_cnt_nxt = (r_cnt != {CW{1'b0}}) ? (r_cnt - CW'(1)) : r_cnt;
            if (w_halt_commit)            w_state_nxt = ST_HALTED;
            else if (w_flush_ack)         w_state_nxt = ST_FLUSH;
            else if (r_cnt <= CW'(1))     w_state_nxt = ST_RUN;
            else                          w_state_nxt = ST_RECOVER;
         end
         ST_HALTED: w_state_nxt = ST_HALTED;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // State, stored flush info and retire counter.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_RUN;
         r_cnt    <= {CW{1'b0}};
         r_tag    <= 32'd0;
         r_target <= 32'd0;
         r_count  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_flush_ack) begin
            r_tag    <= bus.flush_tag;
            r_target <= bus.flush_target;
         end
         if (w_commit_ok) begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   // Output drive: pop/write are same-cycle, flush info is visible only in FLUSH.
   always_comb begin
      bus.rob_pop            = w_commit_ok;
      bus.flush_ack          = w_flush_ack;
      bus.reg_wEn            = w_wen;
      bus.reg_rd             = w_wen ? w_rd : 5'd0;
      bus.reg_data           = w_wen ? bus.rob_head_val : 32'd0;
      bus.rob_flushing_instr = (r_state == ST_FLUSH);
      bus.rob_instr_to_flush = (r_state == ST_FLUSH) ? r_tag : 32'd0;
      bus.pc_redirect_valid  = (r_state == ST_FLUSH);
      bus.pc_redirect        = (r_state == ST_FLUSH) ? r_target : 32'd0;
      bus.dispatch_stall     = (r_state != ST_RUN);
      bus.halted             = (r_state == ST_HALTED);
      bus.commit_count       = r_count;
   end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed scoreboard bench for rob_commit_ctrl (RECOVER_CYCLES=2).
module tb_rob_commit_ctrl;
   logic clk;
   logic rst;

   rob_commit_if u_if ();

   rob_commit_ctrl #(.RECOVER_CYCLES(2), .HALT_OPCODE(5'b11111)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (u_if)
   );

   typedef struct packed {
      logic        pop;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ack;
      logic        fl;
      logic [31:0] ftag;
      logic        rv;
      logic [31:0] pc;
      logic        stall;
      logic        halt;
      logic [31:0] cnt;
   } outs_t;

   outs_t exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
      mk = {op, rd, 22'd0};
   endfunction

   // Monitor: pop one expectation per presented cycle and compare away from the edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         outs_t a;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a.pop   = u_if.rob_pop;
         a.wen   = u_if.reg_wEn;
         a.rd    = u_if.reg_rd;
         a.data  = u_if.reg_data;
         a.ack   = u_if.flush_ack;
         a.fl    = u_if.rob_flushing_instr;
         a.ftag  = u_if.rob_instr_to_flush;
         a.rv    = u_if.pc_redirect_valid;
         a.pc    = u_if.pc_redirect;
         a.stall = u_if.dispatch_stall;
         a.halt  = u_if.halted;
         a.cnt   = u_if.commit_count;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s got pop=%b wen=%b rd=%0d data=%h ack=%b fl=%b tag=%h rv=%b pc=%h stall=%b halt=%b cnt=%0d want pop=%b wen=%b rd=%0d data=%h ack=%b fl=%b tag=%h rv=%b pc=%h stall=%b halt=%b cnt=%0d",
                     n, a.pop, a.wen, a.rd, a.data, a.ack, a.fl, a.ftag, a.rv, a.pc, a.stall, a.halt, a.cnt,
                     e.pop, e.wen, e.rd, e.data, e.ack, e.fl, e.ftag, e.rv, e.pc, e.stall, e.halt, e.cnt);
         end
      end
   end

   task automatic head(input logic empty, input logic ready, input logic [31:0] instr, input logic [31:0] val);
      u_if.rob_is_empty   = empty;
      u_if.rob_head_ready = ready;
      u_if.rob_head_instr = instr;
      u_if.rob_head_val   = val;
   endtask

   task automatic freq(input logic req, input logic [31:0] tag, input logic [31:0] tgt);
      u_if.flush_req    = req;
      u_if.flush_tag    = tag;
      u_if.flush_target = tgt;
   endtask

   // Push the expected outputs for the current input vector, then advance one cycle.
   task automatic cyc(input string nm, input logic pop, input logic wen, input logic [4:0] rd,
                      input logic [31:0] data, input logic ack, input logic fl, input logic [31:0] ftag,
                      input logic [31:0] pc, input logic stall, input logic halt, input logic [31:0] cnt);
      outs_t e;
      e.pop = pop; e.wen = wen; e.rd = rd; e.data = data; e.ack = ack; e.fl = fl;
      e.ftag = ftag; e.rv = fl; e.pc = pc; e.stall = stall; e.halt = halt; e.cnt = cnt;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      head(1'b1, 1'b0, 32'd0, 32'd0);
      freq(1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      cyc("reset_state", 0,0,0,0, 0,0,0,0, 0,0,0);
      rst = 1'b0;

      head(1'b0, 1'b1, mk(5'b00000, 5'd5), 32'h1234);
      cyc("add_commit", 1,1,5,32'h1234, 0,0,0,0, 0,0,0);
      head(1'b0, 1'b1, mk(5'b00111, 5'd3), 32'h55);
      cyc("store_nowrite", 1,0,0,0, 0,0,0,0, 0,0,1);
      head(1'b0, 1'b1, mk(5'b00000, 5'd0), 32'h77);
      cyc("rd0_nowrite", 1,0,0,0, 0,0,0,0, 0,0,2);
      head(1'b0, 1'b0, mk(5'b00000, 5'd6), 32'h9);
      for (int i = 0; i < 3; i++) cyc("not_ready", 0,0,0,0, 0,0,0,0, 0,0,3);
      head(1'b1, 1'b1, 32'd0, 32'h9);
      cyc("empty_ready", 0,0,0,0, 0,0,0,0, 0,0,3);
      head(1'b0, 1'b1, mk(5'b00011, 5'd0), 32'h200);
      cyc("jal_r31", 1,1,31,32'h200, 0,0,0,0, 0,0,3);
      head(1'b0, 1'b1, mk(5'b10101, 5'd1), 32'hAB);
      cyc("setx_r30", 1,1,30,32'hAB, 0,0,0,0, 0,0,4);

      // mispredict with a ready head: accept inhibits the pop
      head(1'b0, 1'b1, mk(5'b00000, 5'd7), 32'h11);
      freq(1'b1, 32'h40, 32'h100);
      cyc("flush_accept", 0,0,0,0, 1,0,0,0, 0,0,5);
      freq(1'b0, 32'h0, 32'h0);
      cyc("flush_cycle", 0,0,0,0, 0,1,32'h40,32'h100, 1,0,5);
      cyc("recover1_commit", 1,1,7,32'h11, 0,0,0,0, 1,0,5);
      head(1'b0, 1'b0, 32'd0, 32'd0);
      cyc("recover2", 0,0,0,0, 0,0,0,0, 1,0,6);
      cyc("back_to_run", 0,0,0,0, 0,0,0,0, 0,0,6);

      // flush during RECOVER, then a request held through FLUSH
      freq(1'b1, 32'h48, 32'h200);
      cyc("flush2_accept", 0,0,0,0, 1,0,0,0, 0,0,6);
      freq(1'b0, 32'h0, 32'h0);
      cyc("flush2_cycle", 0,0,0,0, 0,1,32'h48,32'h200, 1,0,6);
      head(1'b0, 1'b1, mk(5'b00000, 5'd8), 32'h22);
      freq(1'b1, 32'h44, 32'h300);
      cyc("flush_in_recover", 0,0,0,0, 1,0,0,0, 1,0,6);
      freq(1'b1, 32'h4C, 32'h400);
      cyc("held_in_flush", 0,0,0,0, 0,1,32'h44,32'h300, 1,0,6);
      cyc("held_acked_after", 0,0,0,0, 1,0,0,0, 1,0,6);
      freq(1'b0, 32'h0, 32'h0);
      cyc("flush4c_cycle", 0,0,0,0, 0,1,32'h4C,32'h400, 1,0,6);
      cyc("recover_commit", 1,1,8,32'h22, 0,0,0,0, 1,0,6);
      head(1'b0, 1'b0, 32'd0, 32'd0);
      cyc("recover_last", 0,0,0,0, 0,0,0,0, 1,0,7);

      // halt commit, then HALTED ignores heads and flush requests
      head(1'b0, 1'b1, mk(5'b11111, 5'd3), 32'h5);
      cyc("halt_commit", 1,0,0,0, 0,0,0,0, 0,0,7);
      head(1'b0, 1'b1, mk(5'b00000, 5'd9), 32'h1);
      freq(1'b1, 32'h60, 32'h600);
      cyc("halted_1", 0,0,0,0, 0,0,0,0, 1,1,8);
      cyc("halted_2", 0,0,0,0, 0,0,0,0, 1,1,8);
      freq(1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      cyc("halted_reset_cyc", 0,0,0,0, 0,0,0,0, 1,1,8);
      rst = 1'b0;
      head(1'b0, 1'b0, 32'd0, 32'd0);
      cyc("after_reset", 0,0,0,0, 0,0,0,0, 0,0,0);

      // reset while in FLUSH
      freq(1'b1, 32'h50, 32'h500);
      cyc("flush5_accept", 0,0,0,0, 1,0,0,0, 0,0,0);
      freq(1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      cyc("flush5_reset", 0,0,0,0, 0,1,32'h50,32'h500, 1,0,0);
      rst = 1'b0;
      head(1'b0, 1'b1, mk(5'b00000, 5'd2), 32'hC0DE);
      cyc("post_flush_reset", 1,1,2,32'hC0DE, 0,0,0,0, 0,0,0);
      head(1'b1, 1'b0, 32'd0, 32'd0);
      cyc("count_after", 0,0,0,0, 0,0,0,0, 0,0,1);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
In-order retire sequencer for the reorder buffer. Each cycle it inspects the ROB head and, when the head is ready, pops it and writes its result to the architectural register file in the same clock edge. It also sequences branch-mispredict recovery: it accepts a flush request, drives the ROB flush port for one cycle, redirects fetch, and holds dispatch during recovery. It detects a committed halt instruction and maintains a commit counter.

Parameters:
RECOVER_CYCLES, 2, cycles dispatch stays stalled after the flush cycle (>=1)
HALT_OPCODE, 5'b11111, opcode (instr[31:27]) that stops retirement

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rob_is_empty  in  1  ROB empty
rob_head_ready  in  1  head entry finished
rob_head_instr  in  32  head instruction word/tag (0 when empty)
rob_head_val  in  32  head result value
rob_pop  out  1  pop ROB head this edge
rob_flushing_instr  out  1  ROB flush strobe
rob_instr_to_flush  out  32  tag of mispredicted branch; younger entries are flushed
flush_req  in  1  mispredict request from branch unit; held until acked
flush_tag  in  32  branch tag
flush_target  in  32  corrected PC
flush_ack  out  1  request accepted this cycle
pc_redirect_valid  out  1  fetch redirect strobe
pc_redirect  out  32  redirect target
dispatch_stall  out  1  block ROB push / dispatch
reg_wEn  out  1  regfile write enable
reg_rd  out  5  regfile write address
reg_data  out  32  regfile write data
halted  out  1  halt committed
commit_count  out  32  instructions retired, wraps at 2^32

Behaviour:
- FSM states: RUN, FLUSH, RECOVER, HALTED.
- Reset (sampled on clock edge): state=RUN. All outputs 0: stored tag/target 0, recover counter 0, commit_count 0.
- commit_ok = rob_head_ready & !rob_is_empty & (state is RUN or RECOVER) & !flush_ack.
- rob_pop = commit_ok. This is combinational, so the ROB and regfile update on the same edge, with zero latency.
- Decode of the head: opcode=instr[31:27], rd=instr[26:22].
- Non-writers: opcodes 00111 (sw), 00010, 00110 (branches), 00001 (j), 00100 (jr), 10110 (bex), and HALT_OPCODE.
- jal (00011) writes rd=31. setx (10101) writes rd=30.
- reg_wEn = commit_ok & writer & (reg_rd != 0). reg_rd and reg_data are combinational from the head and are 0 when reg_wEn=0. reg_data=rob_head_val.
- commit_count increments by 1 on every edge where commit_ok=1.
- Halt: a commit with opcode==HALT_OPCODE increments commit_count and moves to HALTED next cycle.
  - In HALTED: halted=1, no pops, dispatch_stall=1, flush_req ignored.
  - Only reset exits HALTED.
- Flush acceptance: flush_ack = flush_req & (state is RUN or RECOVER). flush_ack is combinational.
  - In the accept cycle, pop is inhibited so the branch entry cannot retire before its flush.
  - Tag and target are registered on that edge and the FSM goes to FLUSH.
  - flush_req in FLUSH or HALTED is not acked. The requester holds.
- FLUSH (exactly 1 cycle):
  - rob_flushing_instr=1, rob_instr_to_flush=stored tag.
  - pc_redirect_valid=1, pc_redirect=stored target.
  - dispatch_stall=1, rob_pop=0.
  - Next state is RECOVER with the counter loaded to RECOVER_CYCLES.
- RECOVER:
  - dispatch_stall=1, commits allowed.
  - The counter decrements each cycle; when it reaches 1, the next state is RUN.
  - An accepted flush_req in RECOVER restarts at FLUSH with the new tag/target.
- RUN: dispatch_stall=0, rob_flushing_instr=0, pc_redirect_valid=0.
- rob_instr_to_flush and pc_redirect read 0 outside FLUSH.
- Priority in one cycle: reset > halt commit > flush accept > commit.
  - A halt commit and flush_req cannot coincide, because accept inhibits pop.
- Empty ROB: no pop regardless of rob_head_ready.
- Reset during FLUSH/RECOVER returns to RUN with all outputs cleared on the next cycle.

Test Plan:
- Add commit: head instr=opcode 00000, rd=5, val=0x1234, ready=1 -> same cycle rob_pop=1, reg_wEn=1, reg_rd=5, reg_data=0x1234; commit_count 0->1.
- Store and rd=0: head opcode 00111, then opcode 00000 with rd=0, both ready -> rob_pop=1 each cycle, reg_wEn=0 both; commit_count +2.
- Not ready or empty: head_ready=0 for 3 cycles, then rob_is_empty=1 with ready=1 -> rob_pop=0 throughout; count unchanged.
- Mispredict with head ready: flush_req, tag=0x40, target=0x100 -> flush_ack=1 and rob_pop=0 that cycle.
  - Next cycle: rob_flushing_instr=1, rob_instr_to_flush=0x40, pc_redirect_valid=1, pc_redirect=0x100.
  - dispatch_stall high for 1+2 cycles, with commits resuming in RECOVER; then RUN.
- Flush during RECOVER, and during FLUSH:
  - A second flush_req (tag 0x44) in RECOVER is acked and re-enters FLUSH with tag 0x44.
  - A request held during FLUSH is acked only in the following cycle.
- Halt and reset: commit opcode 11111 -> commit_count+1, halted=1 next cycle, later ready heads not popped.
  - Reset asserted -> next cycle halted=0, commit_count=0, state RUN.
